stq_drain_l: RTL and testbench
==============================

STQ_DRAIN_L -- requirements
Module: stq_drain_L

Interface
REQ-001 Parameter: BUF_COUNT, default 32; queue entries per row, must match the store-address buffer array.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: alloc_cnt  input  2  new stores allocated this cycle (0..2).
REQ-005 Port: retire_cnt  input  2  stores committed this cycle (0..2), oldest first.
REQ-006 Port: excpt  input  1  pipeline flush; discards allocated-but-uncommitted entries.
REQ-007 Port: req_vld  output  1  committed store at head is offered to L1.
REQ-008 Port: req_idx  output  5  entry index of the offered store.
REQ-009 Port: req_rdy  input  1  L1 accepts the offered store.
REQ-010 Port: passe_en  output  32  one-hot or two-hot pulse marking committed entries; drives the buffer array passe_en.
REQ-011 Port: free_en  output  32  one-hot pulse freeing drained entries; drives the buffer array free_en.
REQ-012 Port: full  output  1  fewer than 2 free entries.
REQ-013 Port: empty  output  1  no allocated entries.
REQ-014 Port: pend_cnt  output  6  committed-but-undrained entries (0..32).

Function
REQ-015 The block SHALL keep three 6-bit pointers (5-bit index plus wrap bit): head H, retire R, alloc A, with H<=R<=A modulo 64 at all times.
REQ-016 Occupancy SHALL be A-H (6-bit, 0..32); full=(occupancy>=31); empty=(occupancy==0); pend_cnt=R-H.
REQ-017 Allocation SHALL advance A by alloc_cnt only if occupancy+alloc_cnt<=32; otherwise the whole request is ignored and A is unchanged.
REQ-018 Retire SHALL advance R by min(retire_cnt, A-R); excess retire count is dropped silently.
REQ-019 For each entry passed by R in a cycle, passe_en SHALL pulse that entry's bit for exactly one cycle, registered, in the cycle after the retire input; index wraps 31->0.
REQ-020 req_vld SHALL equal (R!=H), and req_idx SHALL equal H[4:0], both decoded from registered state only (no combinational path from req_rdy).
REQ-021 On req_vld&&req_rdy, H SHALL advance by 1 and free_en[old H] SHALL pulse for exactly one cycle, registered, in the next cycle.
REQ-022 req_vld, once asserted, SHALL stay asserted with req_idx stable until accepted; excpt SHALL NOT withdraw it.
REQ-023 On excpt, A SHALL be set to R-after-this-cycle's-retire at the next edge; alloc_cnt in the same cycle SHALL be ignored; retire and drain in the same cycle SHALL proceed normally.
REQ-024 Simultaneous alloc, retire and drain in one cycle SHALL all take effect; occupancy check in REQ-017 SHALL use occupancy before this cycle's drain.
REQ-025 A drained entry SHALL never coincide with a passe_en bit for the same index in the same cycle.

Reset
REQ-026 While rst is low: H=R=A=0, req_vld=0, req_idx=0, passe_en=0, free_en=0, full=0, empty=1, pend_cnt=0, asynchronously.
REQ-027 A reset asserted mid-operation SHALL discard all pointers and pulses; no free_en or passe_en SHALL appear after rst deasserts until new retires/drains occur.

Verification
REQ-028 Reset, then alloc_cnt=2 x3, retire_cnt=2 x1 -> passe_en=0x3 one cycle later, pend_cnt=2, req_vld=1, req_idx=0.
REQ-029 req_rdy held 1 with 2 committed -> free_en=0x1 then 0x2 on consecutive cycles, req_vld drops, pend_cnt=0, empty=0 (4 still allocated).
REQ-030 Fill to 31 entries -> full=1; alloc_cnt=2 ignored (A unchanged); alloc_cnt=1 accepted -> occupancy 32.
REQ-031 H=R=A=31, alloc 2, retire 2 -> passe_en=0x8000_0001 (wrap), drains in order idx 31 then 0.
REQ-032 6 allocated, 2 retired, excpt with retire_cnt=1 -> A=R=3, occupancy 3, pend_cnt 3, req_vld held through flush.
REQ-033 rst low while req_vld=1 and passe_en pulsing -> all outputs to reset values immediately, empty=1.

Source files
------------

// File: rtl/stq_drain_l.sv
// Store-queue drain control: head/retire/alloc pointers, L1 drain handshake,
// and the registered passe_en/free_en pulses that drive the store-address buffer array.
module stq_drain_l #(
    parameter int BUF_COUNT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   alloc_cnt,
    input  logic [1:0]                   retire_cnt,
    input  logic                         excpt,
    output logic                         req_vld,
    output logic [$clog2(BUF_COUNT)-1:0] req_idx,
    input  logic                         req_rdy,
    output logic [BUF_COUNT-1:0]         passe_en,
    output logic [BUF_COUNT-1:0]         free_en,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(BUF_COUNT):0]   pend_cnt
);
    localparam int IW = $clog2(BUF_COUNT);
    localparam int PW = IW + 1;
    localparam logic [PW:0]   CAP  = (PW+1)'(BUF_COUNT);
    localparam logic [PW-1:0] FULL = PW'(BUF_COUNT - 1);

    // Pointers carry a wrap bit so a full queue (A-H == BUF_COUNT) is distinguishable from empty.
    logic [PW-1:0]        r_h, r_r, r_a;
    logic [BUF_COUNT-1:0] r_passe, r_free;

    logic [PW-1:0]        w_occ, w_room, w_r_nxt;
    logic [1:0]           w_ret_n;
    logic                 w_alloc_ok, w_drain;
    logic [BUF_COUNT-1:0] w_passe_nxt, w_free_nxt;

    assign w_occ      = r_a - r_h;
    assign w_room     = r_a - r_r;
    assign w_ret_n    = (PW'(retire_cnt) > w_room) ? w_room[1:0] : retire_cnt;
    assign w_r_nxt    = r_r + PW'(w_ret_n);
    // Occupancy check uses the pre-drain head; a flush cancels same-cycle allocation.
    assign w_alloc_ok = !excpt && (({1'b0, w_occ} + (PW+1)'(alloc_cnt)) <= CAP);
    assign w_drain    = req_vld && req_rdy;

    always_comb begin
        w_passe_nxt = '0;
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < w_ret_n)
                w_passe_nxt[r_r[IW-1:0] + IW'(k)] = 1'b1;
        end
    end

    always_comb begin
        w_free_nxt = '0;
        if (w_drain)
            w_free_nxt[r_h[IW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h     <= '0;
            r_r     <= '0;
            r_a     <= '0;
            r_passe <= '0;
            r_free  <= '0;
        end else begin
            r_h     <= r_h + PW'(w_drain);
            r_r     <= w_r_nxt;
            if (excpt)
                r_a <= w_r_nxt;
            else if (w_alloc_ok)
                r_a <= r_a + PW'(alloc_cnt);
            r_passe <= w_passe_nxt;
            r_free  <= w_free_nxt;
        end
    end

    assign req_vld  = (r_r != r_h);
    assign req_idx  = r_h[IW-1:0];
    assign passe_en = r_passe;
    assign free_en  = r_free;
    assign full     = (w_occ >= FULL);
    assign empty    = (w_occ == '0);
    assign pend_cnt = r_r - r_h;
endmodule

// File: tb/tb_stq_drain_l.sv
// Directed bench for stq_drain_l: stimulus pushes expected pulses/handshakes into
// queues, a negedge monitor pops and compares them; status outputs are checked inline.
module tb_stq_drain_l;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_cnt, retire_cnt;
    logic        excpt, req_rdy;
    logic        req_vld;
    logic [4:0]  req_idx;
    logic [31:0] passe_en, free_en;
    logic        full, empty;
    logic [5:0]  pend_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int ex_r = 0;
    int ex_h = 0;

    logic [31:0] q_passe[$];
    logic [31:0] q_free[$];
    logic [4:0]  q_req[$];

    stq_drain_l #(.BUF_COUNT(32)) dut (
        .clk(clk), .rst(rst), .alloc_cnt(alloc_cnt), .retire_cnt(retire_cnt),
        .excpt(excpt), .req_vld(req_vld), .req_idx(req_idx), .req_rdy(req_rdy),
        .passe_en(passe_en), .free_en(free_en), .full(full), .empty(empty),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (passe_en != 0) begin
                if (q_passe.size() == 0) chk("passe_unexpected", passe_en, 32'h0);
                else chk("passe_en", passe_en, q_passe.pop_front());
            end
            if (free_en != 0) begin
                if (q_free.size() == 0) chk("free_unexpected", free_en, 32'h0);
                else chk("free_en", free_en, q_free.pop_front());
            end
            if (req_vld && req_rdy) begin
                if (q_req.size() == 0) chk("req_unexpected", {27'h0, req_idx}, 32'hffff_ffff);
                else chk("req_idx_hs", {27'h0, req_idx}, {27'h0, q_req.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_cyc(input int cnt);
        alloc_cnt = 2'(cnt);
        step();
        alloc_cnt = 2'd0;
    endtask

    // n = number of entries expected to actually retire (after clamping)
    task automatic retire_cyc(input int cnt, input int n);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < n; i++) m[(ex_r + i) % 32] = 1'b1;
        if (n > 0) q_passe.push_back(m);
        ex_r += n;
        retire_cnt = 2'(cnt);
        step();
        retire_cnt = 2'd0;
    endtask

    task automatic drain(input int n);
        logic [31:0] m;
        for (int i = 0; i < n; i++) begin
            m = 32'h0;
            m[(ex_h + i) % 32] = 1'b1;
            q_free.push_back(m);
            q_req.push_back(5'((ex_h + i) % 32));
        end
        ex_h += n;
        req_rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
        req_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; alloc_cnt = 0; retire_cnt = 0; excpt = 0; req_rdy = 0;
        #12;
        chk("rst_req_vld", {31'h0, req_vld}, 32'h0);
        chk("rst_req_idx", {27'h0, req_idx}, 32'h0);
        chk("rst_empty",   {31'h0, empty}, 32'h1);
        chk("rst_full",    {31'h0, full}, 32'h0);
        chk("rst_pend",    {26'h0, pend_cnt}, 32'h0);
        chk("rst_passe",   passe_en, 32'h0);
        chk("rst_free",    free_en, 32'h0);
        @(negedge clk); rst = 1'b1;
        step(); step();

        // three double allocations, one double retire
        for (int i = 0; i < 3; i++) alloc_cyc(2);
        chk("alloc6_empty", {31'h0, empty}, 32'h0);
        retire_cyc(2, 2);
        chk("ret2_passe_direct", passe_en, 32'h0000_0003);
        chk("ret2_pend",    {26'h0, pend_cnt}, 32'd2);
        chk("ret2_req_vld", {31'h0, req_vld}, 32'h1);
        chk("ret2_req_idx", {27'h0, req_idx}, 32'd0);

        // drain both committed stores back to back
        drain(2);
        chk("drain_req_vld", {31'h0, req_vld}, 32'h0);
        chk("drain_pend",    {26'h0, pend_cnt}, 32'd0);
        chk("drain_empty",   {31'h0, empty}, 32'h0);

        // fill: occupancy 4 -> 30 -> 31 (full) -> reject 2 -> accept 1 -> reject 1
        for (int i = 0; i < 13; i++) alloc_cyc(2);
        chk("occ30_full", {31'h0, full}, 32'h0);
        alloc_cyc(1);
        chk("occ31_full", {31'h0, full}, 32'h1);
        alloc_cyc(2);
        chk("occ31_rej_full", {31'h0, full}, 32'h1);
        alloc_cyc(1);
        alloc_cyc(1);
        chk("occ32_full", {31'h0, full}, 32'h1);
        for (int i = 0; i < 16; i++) retire_cyc(2, 2);
        chk("occ32_pend", {26'h0, pend_cnt}, 32'd32);
        retire_cyc(2, 0);
        chk("over_retire_pend", {26'h0, pend_cnt}, 32'd32);
        drain(32);
        chk("drain32_empty", {31'h0, empty}, 32'h1);
        chk("drain32_full",  {31'h0, full}, 32'h0);
        chk("drain32_vld",   {31'h0, req_vld}, 32'h0);

        // walk pointers from 34 to 63 (index 31)
        for (int i = 0; i < 14; i++) alloc_cyc(2);
        alloc_cyc(1);
        for (int i = 0; i < 14; i++) retire_cyc(2, 2);
        retire_cyc(1, 1);
        drain(29);
        chk("at31_idx",   {27'h0, req_idx}, 32'd31);
        chk("at31_empty", {31'h0, empty}, 32'h1);
        alloc_cyc(2);
        retire_cyc(2, 2);
        chk("wrap_passe_direct", passe_en, 32'h8000_0001);
        chk("wrap_req_idx", {27'h0, req_idx}, 32'd31);
        drain(2);
        chk("wrap_drained", {31'h0, empty}, 32'h1);

        // flush: H=R=A=1; allocate 6, retire 2, then excpt with retire 1 and alloc 2
        for (int i = 0; i < 3; i++) alloc_cyc(2);
        retire_cyc(2, 2);
        excpt = 1'b1; alloc_cnt = 2'd2;
        chk("flush_vld_pre", {31'h0, req_vld}, 32'h1);
        retire_cyc(1, 1);
        excpt = 1'b0; alloc_cnt = 2'd0;
        chk("flush_pend",    {26'h0, pend_cnt}, 32'd3);
        chk("flush_vld",     {31'h0, req_vld}, 32'h1);
        chk("flush_idx",     {27'h0, req_idx}, 32'd1);
        retire_cyc(1, 0);
        chk("flush_occ_eq_pend", {26'h0, pend_cnt}, 32'd3);

        // simultaneous alloc + retire + drain: H=1 R=4 A=6 -> H=2 R=6 A=8
        alloc_cyc(2);
        q_free.push_back(32'h0000_0002);
        q_req.push_back(5'd1);
        q_passe.push_back(32'h0000_0030);
        ex_h += 1; ex_r += 2;
        alloc_cnt = 2'd2; retire_cnt = 2'd2; req_rdy = 1'b1;
        step();
        alloc_cnt = 2'd0; retire_cnt = 2'd0; req_rdy = 1'b0;
        chk("simul_pend", {26'h0, pend_cnt}, 32'd4);
        chk("simul_idx",  {27'h0, req_idx}, 32'd2);

        // reset mid-operation while passe_en is pulsing
        retire_cnt = 2'd1;
        step();
        retire_cnt = 2'd0;
        chk("prerst_passe", passe_en, 32'h0000_0040);
        chk("prerst_vld",   {31'h0, req_vld}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_vld",   {31'h0, req_vld}, 32'h0);
        chk("midrst_passe", passe_en, 32'h0);
        chk("midrst_empty", {31'h0, empty}, 32'h1);
        chk("midrst_pend",  {26'h0, pend_cnt}, 32'h0);
        chk("midrst_idx",   {27'h0, req_idx}, 32'h0);
        @(negedge clk); rst = 1'b1;
        ex_r = 0; ex_h = 0;
        for (int i = 0; i < 4; i++) step();
        chk("postrst_empty", {31'h0, empty}, 32'h1);
        chk("postrst_vld",   {31'h0, req_vld}, 32'h0);
        alloc_cyc(2);
        retire_cyc(1, 1);
        chk("postrst_pend", {26'h0, pend_cnt}, 32'd1);
        chk("postrst_idx",  {27'h0, req_idx}, 32'd0);
        step(); step();

        chk("q_passe_left", q_passe.size(), 32'd0);
        chk("q_free_left",  q_free.size(), 32'd0);
        chk("q_req_left",   q_req.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
